store_commit_unit: RTL and testbench
====================================

Name: store_commit_unit

Overview:
- Downstream consumer of the reorder buffer's store path. Takes the store at the ROB head (effective address plus data), performs the data-memory write over a req/ack handshake, then returns a one-cycle completion pulse so the ROB retires the entry.
- Sits between the ROB commit port and the data-memory write port.
- Stores leave the core only in program order, one at a time.

Parameters:
- ADDR_WIDTH, 32, byte-address width driven to memory.
- TIMEOUT, 64, maximum cycles to wait for mem_ack_in before declaring a fault.
- CNT_WIDTH, 16, width of the committed-store counter.

Ports:
- clk_in  input  1  system clock, all logic on posedge.
- rst_in  input  1  synchronous active-high reset.
- store_valid_in  input  1  ROB head is a ready store.
- store_addr_in  input  32  effective byte address from the ROB dest field.
- store_data_in  input  32  store data from the ROB value field.
- store_size_in  input  2  0 = byte, 1 = half, 2 = word; used only with the optional feature.
- store_read_out  input-side pulse to ROB  output  1  one-cycle pulse; the ROB advances head on it.
- mem_req_out  output  1  write request, held until acknowledged.
- mem_addr_out  output  ADDR_WIDTH  byte address, word-aligned (low 2 bits zero).
- mem_wdata_out  output  32  write data.
- mem_wstrb_out  output  4  byte strobes.
- mem_ack_in  input  1  memory accepted the write.
- busy_out  output  1  high in any state other than IDLE.
- fault_out  output  1  sticky timeout fault.
- store_count_out  output  CNT_WIDTH  number of completed stores.

Behaviour:
- Reset: one clock, synchronous, active-high; all outputs are 0 and the FSM is in IDLE. Reset taken mid-transaction aborts the transaction with no store_read_out pulse.
- FSM states are IDLE, REQ, DONE and FAULT.
- IDLE:
  - If store_valid_in, latch addr/data/size into holding registers, go to REQ.
  - Latency from store_valid_in to the first mem_req_out is 1 cycle.
- REQ:
  - mem_req_out = 1. addr/wdata/wstrb come from the holding registers and stay stable while req is high.
  - A wait counter increments each cycle.
  - If mem_ack_in, go to DONE; an ack in the first REQ cycle is legal.
  - If the wait counter reaches TIMEOUT with no ack, go to FAULT.
- DONE:
  - store_read_out = 1 for exactly this cycle; store_count_out increments, wrapping modulo 2^CNT_WIDTH.
  - Next state is IDLE unconditionally.
  - The ROB head has advanced by the next edge, so a store_valid_in seen in IDLE always refers to a new entry. Back-to-back stores therefore take 3 cycles minimum each (IDLE, REQ, DONE).
- FAULT:
  - fault_out = 1, mem_req_out = 0, busy_out = 1.
  - No further stores are accepted; the state is left only by reset.
- Signals are ignored outside their own states: mem_ack_in outside REQ, and store_valid_in outside IDLE.
- Store inputs are sampled only on the IDLE→REQ edge; later changes have no effect.
- Word alignment: mem_addr_out = {addr[ADDR_WIDTH-1:2], 2'b00}.

Optional Feature:
- Macro: STORE_SUBWORD_EN.
- Defined:
  - byte stores: wstrb = 4'b0001 << addr[1:0], and wdata = {4{data[7:0]}}.
  - half stores: wstrb = 4'b0011 << {addr[1],1'b0}, and wdata = {2{data[15:0]}}.
  - word stores: wstrb = 4'b1111.
  - A misaligned half (addr[0] = 1) or misaligned word (addr[1:0] != 0) goes straight to FAULT with no memory request.
- Undefined:
  - store_size_in is ignored; every store is a full word with wstrb = 4'b1111 and wdata = data.
  - addr[1:0] is dropped silently; no alignment fault.

Test Plan:
- Reset then idle: rst_in high 2 cycles, then 5 idle cycles → all outputs 0 and store_count_out = 0.
- Single word store: valid with addr 0x0000_1008, data 0xDEAD_BEEF, ack on the 2nd REQ cycle → mem_req_out high 2 cycles with addr 0x1008, wstrb 4'hF; store_read_out pulses once; count = 1.
- Back-to-back: two stores held valid, ack immediately each time → req asserted in cycle 1 and again in cycle 4; exactly two store_read_out pulses; count = 2; second address and data correct.
- Timeout: TIMEOUT = 8, ack never returned → mem_req_out high 8 cycles, then fault_out = 1 sticky; store_valid_in ignored; rst_in clears it.
- Reset mid-REQ: assert rst_in during REQ → next cycle mem_req_out = 0, no store_read_out pulse, count unchanged (0).
- STORE_SUBWORD_EN:
  - byte store to 0x1003, data 0xAB → wstrb 4'b1000, wdata 0xABABABAB.
  - half store to 0x1001 → FAULT with no req.

Source files
------------

// File: rtl/store_commit_unit.sv
// Store commit unit: writes the ROB-head store to data memory over a req/ack
// handshake, then pulses store_read_out so the ROB retires it. Optional sub-word
// byte/half stores with alignment checking are enabled by defining STORE_SUBWORD_EN.
module store_commit_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  store_valid_in,
    input  logic [ADDR_WIDTH-1:0] store_addr_in,
    input  logic [31:0]           store_data_in,
    input  logic [1:0]            store_size_in,
    output logic                  store_read_out,
    output logic                  mem_req_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [31:0]           mem_wdata_out,
    output logic [3:0]            mem_wstrb_out,
    input  logic                  mem_ack_in,
    output logic                  busy_out,
    output logic                  fault_out,
    output logic [CNT_WIDTH-1:0]  store_count_out
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic [31:0]           lane_wdata;
    logic [3:0]            lane_wstrb;
    logic                  misaligned;

    // Lane steering is computed from the live inputs and captured only on IDLE->REQ.
    always_comb begin
        lane_wdata = store_data_in;
        lane_wstrb = 4'b1111;
        misaligned = 1'b0;
`ifdef STORE_SUBWORD_EN
        case (store_size_in)
            2'd0: begin
                lane_wstrb = 4'b0001 << store_addr_in[1:0];
                lane_wdata = {4{store_data_in[7:0]}};
            end
            2'd1: begin
                lane_wstrb = 4'b0011 << {store_addr_in[1], 1'b0};
                lane_wdata = {2{store_data_in[15:0]}};
                misaligned = store_addr_in[0];
            end
            default: begin
                misaligned = |store_addr_in[1:0];
            end
        endcase
`endif
    end

`ifndef STORE_SUBWORD_EN
    // Size and low address bits carry no meaning for full-word-only stores.
    logic unused_subword;
    assign unused_subword = ^{store_size_in, store_addr_in[1:0]};
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        wstrb_d        = wstrb_q;
        wait_d         = wait_q;
        count_d        = count_q;
        store_read_out = 1'b0;
        mem_req_out    = 1'b0;
        busy_out       = 1'b1;
        fault_out      = 1'b0;

        case (state_q)
            IDLE: begin
                busy_out = 1'b0;
                wait_d   = '0;
                if (store_valid_in) begin
                    addr_d  = {store_addr_in[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = lane_wdata;
                    wstrb_d = lane_wstrb;
                    state_d = misaligned ? FAULT : REQ;
                end
            end
            REQ: begin
                mem_req_out = 1'b1;
                if (mem_ack_in) begin
                    state_d = DONE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = FAULT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                store_read_out = 1'b1;
                count_d        = count_q + 1'b1;
                state_d        = IDLE;
            end
            FAULT: begin
                fault_out = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory address/data are forced to zero whenever no request is outstanding.
    assign mem_addr_out    = mem_req_out ? addr_q  : '0;
    assign mem_wdata_out   = mem_req_out ? wdata_q : '0;
    assign mem_wstrb_out   = mem_req_out ? wstrb_q : '0;
    assign store_count_out = count_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_store_commit_unit.sv
// Self-checking bench for store_commit_unit: directed scenarios plus randomized
// stores checked against a transaction-level model (sub-word cases under STORE_SUBWORD_EN).
module tb_store_commit_unit;

    localparam int AW = 32;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          store_valid;
    logic [AW-1:0] store_addr;
    logic [31:0]   store_data;
    logic [1:0]    store_size;
    logic          store_read;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack;
    logic          busy;
    logic          fault;
    logic [CW-1:0] store_count;

    int            n_checks = 0;
    int            n_errors = 0;
    int            pulse_cnt = 0;
    logic [CW-1:0] exp_count;

    always #5 clk = ~clk;

    store_commit_unit #(
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .store_valid_in (store_valid),
        .store_addr_in  (store_addr),
        .store_data_in  (store_data),
        .store_size_in  (store_size),
        .store_read_out (store_read),
        .mem_req_out    (mem_req),
        .mem_addr_out   (mem_addr),
        .mem_wdata_out  (mem_wdata),
        .mem_wstrb_out  (mem_wstrb),
        .mem_ack_in     (mem_ack),
        .busy_out       (busy),
        .fault_out      (fault),
        .store_count_out(store_count)
    );

    always @(negedge clk) begin
        if (store_read === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected byte lanes for a store, straight from the size/address rules.
    function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [1:0] s);
`ifdef STORE_SUBWORD_EN
        case (s)
            2'd0:    return 4'(1 << a[1:0]);
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
`else
        return 4'b1111;
`endif
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] s);
`ifdef STORE_SUBWORD_EN
        case (s)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
`else
        return d;
`endif
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_req"},   32'(mem_req),    32'd0);
        check({tag, "_read"},  32'(store_read), 32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_fault"}, 32'(fault),      32'd0);
        check({tag, "_addr"},  mem_addr,        32'd0);
        check({tag, "_wstrb"}, 32'(mem_wstrb),  32'd0);
        check({tag, "_count"}, 32'(store_count), 32'(exp_count));
    endtask

    // One store from IDLE; ack arrives on REQ cycle (delay+1). Noise on ignored inputs.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input int delay);
        store_valid = 1'b1;
        store_addr  = a;
        store_data  = d;
        store_size  = s;
        tick;
        store_addr = $urandom;
        store_data = $urandom;
        store_size = 2'($urandom);
        for (int i = 0; i <= delay; i++) begin
            check("st_req",   32'(mem_req),    32'd1);
            check("st_addr",  mem_addr,        a & 32'hFFFF_FFFC);
            check("st_wdata", mem_wdata,       exp_wdata(d, s));
            check("st_wstrb", 32'(mem_wstrb),  32'(exp_strb(a, s)));
            check("st_noread", 32'(store_read), 32'd0);
            mem_ack     = (i == delay);
            store_valid = 1'($urandom_range(0, 1));
            tick;
        end
        check("st_pulse",   32'(store_read), 32'd1);
        check("st_req_off", 32'(mem_req),    32'd0);
        check("st_busy",    32'(busy),       32'd1);
        exp_count++;
        mem_ack     = 1'($urandom_range(0, 1));
        store_valid = 1'b0;
        tick;
        mem_ack = 1'b0;
        check("st_pulse_end", 32'(store_read),  32'd0);
        check("st_idle",      32'(busy),        32'd0);
        check("st_count",     32'(store_count), 32'(exp_count));
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        exp_count = '0;
    endtask

    initial begin
        int p0;
        logic [31:0] ra;
        logic [1:0]  rs;

        rst = 1'b1; store_valid = 1'b0; store_addr = '0; store_data = '0;
        store_size = '0; mem_ack = 1'b0; exp_count = '0;

        // Reset then idle
        do_reset;
        for (int i = 0; i < 5; i++) begin
            check_quiet("reset_idle");
            tick;
        end

        // Single word store, ack on second REQ cycle
        do_store(32'h0000_1008, 32'hDEAD_BEEF, 2'd2, 1);

        // Back-to-back stores with valid and ack held high
        p0 = pulse_cnt;
        store_valid = 1'b1; store_addr = 32'h0000_2004; store_data = 32'h1111_2222;
        store_size = 2'd2; mem_ack = 1'b1;
        tick;
        check("b2b_req1",  32'(mem_req),  32'd1);
        check("b2b_addr1", mem_addr,      32'h0000_2004);
        check("b2b_data1", mem_wdata,     32'h1111_2222);
        store_addr = 32'h0000_300C; store_data = 32'h3333_4444;
        tick;
        check("b2b_done1", 32'(store_read), 32'd1);
        tick;
        check("b2b_gap_req", 32'(mem_req), 32'd0);
        check("b2b_count1", 32'(store_count), 32'(exp_count + 16'd1));
        tick;
        check("b2b_req2",  32'(mem_req), 32'd1);
        check("b2b_addr2", mem_addr,     32'h0000_300C);
        check("b2b_data2", mem_wdata,    32'h3333_4444);
        store_valid = 1'b0;
        tick;
        check("b2b_done2", 32'(store_read), 32'd1);
        mem_ack = 1'b0;
        tick;
        exp_count += 16'd2;
        check("b2b_count2", 32'(store_count), 32'(exp_count));
        check("b2b_pulses", 32'(pulse_cnt - p0), 32'd2);

        // Randomized stores against the model
        p0 = pulse_cnt;
        for (int n = 0; n < 30; n++) begin
            ra = $urandom;
`ifdef STORE_SUBWORD_EN
            rs = 2'($urandom_range(0, 2));
            if (rs == 2'd1) ra[0] = 1'b0;
            if (rs == 2'd2) ra[1:0] = 2'b00;
`else
            rs = 2'($urandom);
`endif
            do_store(ra, $urandom, rs, $urandom_range(0, TO - 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                check_quiet("rand_gap");
                tick;
            end
        end
        check("rand_pulses", 32'(pulse_cnt - p0), 32'd30);

`ifdef STORE_SUBWORD_EN
        // Byte store lands on the top lane with replicated data
        store_valid = 1'b1; store_addr = 32'h0000_1003; store_data = 32'h0000_00AB;
        store_size = 2'd0;
        tick;
        store_valid = 1'b0;
        check("byte_wstrb", 32'(mem_wstrb), 32'h8);
        check("byte_wdata", mem_wdata,      32'hABAB_ABAB);
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        tick;
        exp_count++;
        check("byte_count", 32'(store_count), 32'(exp_count));

        // Misaligned half goes straight to FAULT
        store_valid = 1'b1; store_addr = 32'h0000_1001; store_size = 2'd1;
        tick;
        store_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("mis_req",   32'(mem_req), 32'd0);
            check("mis_fault", 32'(fault),   32'd1);
            tick;
        end
        do_reset;
        check_quiet("mis_reset");
`endif

        // Reset taken mid-REQ aborts with no completion pulse
        p0 = pulse_cnt;
        store_valid = 1'b1; store_addr = 32'h0000_4000; store_data = 32'h5555_AAAA;
        store_size = 2'd2;
        tick;
        store_valid = 1'b0;
        check("midreq_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_count = '0;
        check_quiet("midreq_abort");
        tick;
        tick;
        check("midreq_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("midreq_count",  32'(store_count),    32'd0);

        // Timeout: no ack for TO cycles, fault is sticky until reset
        store_valid = 1'b1; store_addr = 32'h0000_5008; store_data = 32'h0BAD_F00D;
        store_size = 2'd2;
        tick;
        store_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            check("to_req",   32'(mem_req), 32'd1);
            check("to_fault", 32'(fault),   32'd0);
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            check("to_req_off", 32'(mem_req),    32'd0);
            check("to_fault",   32'(fault),      32'd1);
            check("to_busy",    32'(busy),       32'd1);
            check("to_noread",  32'(store_read), 32'd0);
            store_valid = 1'b1;
            mem_ack = 1'($urandom_range(0, 1));
            tick;
        end
        store_valid = 1'b0;
        mem_ack = 1'b0;
        do_reset;
        check_quiet("to_cleared");
        tick;
        check_quiet("to_cleared2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
